// File: rtl/sc_enccounter.sv
// sc_enccounter -- quadrature encoder window counter.
//
// Decodes one encoder's A/B channels in x4 mode and accumulates signed ticks
// over a fixed window of ENCCOUNTER_WINDOW_CYCLES clocks. At the end of each
// window it publishes the saturated count together with a one-cycle low load
// strobe for a downstream register. Windows run back to back while enabled.
//
// Parameters:
//   ENCCOUNTER_DATAWIDTH      width of the two's complement count
//   ENCCOUNTER_WINDOW_CYCLES  window length in clocks (>= 2)
//
// Ports:
//   SC_ENCCOUNTER_CLOCK_50          system clock (only clock)
//   SC_ENCCOUNTER_RESET_InLow       synchronous active-low reset
//   SC_ENCCOUNTER_enable_InHigh     1 = run windows, 0 = idle
//   SC_ENCCOUNTER_chA_In / chB_In   encoder channels
//   SC_ENCCOUNTER_data_OutBus       signed count of the last completed window
//   SC_ENCCOUNTER_load_OutLow       one-cycle low strobe, data valid while low
//   SC_ENCCOUNTER_overflow_OutHigh  last window saturated
//   SC_ENCCOUNTER_error_OutHigh     last window saw an illegal A/B transition
//
// Build option:
//   SC_ENCCOUNTER_SYNC_EN  when defined, A and B pass through two-flop
//                          synchronizers and the FSM dwells in IDLE for two
//                          cycles after reset while those flops fill.
module sc_enccounter #(
  parameter int ENCCOUNTER_DATAWIDTH     = 32,
  parameter int ENCCOUNTER_WINDOW_CYCLES = 500000
) (
  input  logic                            SC_ENCCOUNTER_CLOCK_50,
  input  logic                            SC_ENCCOUNTER_RESET_InLow,
  input  logic                            SC_ENCCOUNTER_enable_InHigh,
  input  logic                            SC_ENCCOUNTER_chA_In,
  input  logic                            SC_ENCCOUNTER_chB_In,
  output logic [ENCCOUNTER_DATAWIDTH-1:0] SC_ENCCOUNTER_data_OutBus,
  output logic                            SC_ENCCOUNTER_load_OutLow,
  output logic                            SC_ENCCOUNTER_overflow_OutHigh,
  output logic                            SC_ENCCOUNTER_error_OutHigh
);

  localparam int CNT_W = $clog2(ENCCOUNTER_WINDOW_CYCLES);
  localparam int DW    = ENCCOUNTER_DATAWIDTH;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ENCCOUNTER_WINDOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [DW-1:0]    ACC_ONE  = DW'(1);
  localparam logic [DW-1:0]    ACC_MAX  = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0]    ACC_MIN  = {1'b1, {(DW-1){1'b0}}};

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } stateT;

  logic [1:0] rawAB;
  logic [1:0] curAB;
  logic       startAllowed;

  assign rawAB = {SC_ENCCOUNTER_chA_In, SC_ENCCOUNTER_chB_In};

`ifdef SC_ENCCOUNTER_SYNC_EN
  // One two-flop synchronizer per channel; bit 1 is A, bit 0 is B.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : genSync
      logic stage1Reg;
      logic stage2Reg;
      always_ff @(posedge SC_ENCCOUNTER_CLOCK_50) begin
        if (!SC_ENCCOUNTER_RESET_InLow) begin
          stage1Reg <= 1'b0;
          stage2Reg <= 1'b0;
        end else begin
          stage1Reg <= rawAB[gi];
          stage2Reg <= stage1Reg;
        end
      end
      assign curAB[gi] = stage2Reg;
    end
  endgenerate

  // Holds the FSM in IDLE until the synchronizers carry real channel data,
  // so the 0 -> input transition out of reset is never counted.
  logic [1:0] dwellReg;
  always_ff @(posedge SC_ENCCOUNTER_CLOCK_50) begin
    if (!SC_ENCCOUNTER_RESET_InLow) begin
      dwellReg <= 2'd2;
    end else if (dwellReg != 2'd0) begin
      dwellReg <= dwellReg - 2'd1;
    end
  end
  assign startAllowed = (dwellReg == 2'd0);
`else
  assign curAB        = rawAB;
  assign startAllowed = 1'b1;
`endif

  // ---------------------------------------------------------------------------
  // x4 decode. Mapping the Gray sequence 00,01,11,10 onto positions 0..3
  // (pos = {A, A^B}) turns direction into a modulo-4 difference:
  // +1 forward, -1 (3) reverse, 2 means both bits flipped (illegal).
  // ---------------------------------------------------------------------------
  logic [1:0] prevABReg;
  logic [1:0] curPos;
  logic [1:0] prevPos;
  logic [1:0] posDiff;
  logic       stepUp;
  logic       stepDown;
  logic       illegalStep;

  assign curPos      = {curAB[1], curAB[1] ^ curAB[0]};
  assign prevPos     = {prevABReg[1], prevABReg[1] ^ prevABReg[0]};
  assign posDiff     = curPos - prevPos;
  assign stepUp      = (posDiff == 2'd1);
  assign stepDown    = (posDiff == 2'd3);
  assign illegalStep = (posDiff == 2'd2);

  // ---------------------------------------------------------------------------
  // Saturating accumulate of this cycle's step.
  // ---------------------------------------------------------------------------
  logic [DW-1:0] accReg;
  logic [DW-1:0] accNext;
  logic          satHit;

  always_comb begin
    accNext = accReg;
    satHit  = 1'b0;
    if (stepUp) begin
      if (accReg == ACC_MAX) begin
        satHit = 1'b1;
      end else begin
        accNext = accReg + ACC_ONE;
      end
    end else if (stepDown) begin
      if (accReg == ACC_MIN) begin
        satHit = 1'b1;
      end else begin
        accNext = accReg - ACC_ONE;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Window FSM with registered outputs.
  // ---------------------------------------------------------------------------
  stateT          stateReg;
  logic [CNT_W-1:0] cntReg;
  logic           ovfFlagReg;
  logic           errFlagReg;
  logic [DW-1:0]  dataReg;
  logic           loadReg;
  logic           ovfOutReg;
  logic           errOutReg;

  always_ff @(posedge SC_ENCCOUNTER_CLOCK_50) begin
    if (!SC_ENCCOUNTER_RESET_InLow) begin
      stateReg   <= IDLE;
      prevABReg  <= curAB;
      accReg     <= '0;
      cntReg     <= '0;
      ovfFlagReg <= 1'b0;
      errFlagReg <= 1'b0;
      dataReg    <= '0;
      loadReg    <= 1'b1;
      ovfOutReg  <= 1'b0;
      errOutReg  <= 1'b0;
    end else begin
      prevABReg <= curAB;
      // The strobe is low for one cycle only; any publish below overrides.
      loadReg   <= 1'b1;
      case (stateReg)
        IDLE: begin
          accReg     <= '0;
          cntReg     <= '0;
          ovfFlagReg <= 1'b0;
          errFlagReg <= 1'b0;
          if (SC_ENCCOUNTER_enable_InHigh && startAllowed) begin
            stateReg <= COUNT;
          end
        end
        COUNT: begin
          if (!SC_ENCCOUNTER_enable_InHigh) begin
            // Partial window is dropped; published outputs keep their values.
            stateReg   <= IDLE;
            accReg     <= '0;
            cntReg     <= '0;
            ovfFlagReg <= 1'b0;
            errFlagReg <= 1'b0;
          end else if (cntReg == CNT_LAST) begin
            // Terminal cycle: publish including this cycle's step and events,
            // then start the next window immediately.
            dataReg    <= accNext;
            ovfOutReg  <= ovfFlagReg | satHit;
            errOutReg  <= errFlagReg | illegalStep;
            loadReg    <= 1'b0;
            accReg     <= '0;
            cntReg     <= '0;
            ovfFlagReg <= 1'b0;
            errFlagReg <= 1'b0;
          end else begin
            accReg     <= accNext;
            cntReg     <= cntReg + CNT_ONE;
            ovfFlagReg <= ovfFlagReg | satHit;
            errFlagReg <= errFlagReg | illegalStep;
          end
        end
        default: stateReg <= IDLE;
      endcase
    end
  end

  assign SC_ENCCOUNTER_data_OutBus      = dataReg;
  assign SC_ENCCOUNTER_load_OutLow      = loadReg;
  assign SC_ENCCOUNTER_overflow_OutHigh = ovfOutReg;
  assign SC_ENCCOUNTER_error_OutHigh    = errOutReg;

endmodule

// File: tb/tb_sc_enccounter.sv
// Directed bench for sc_enccounter. The main instance uses an 8-bit count and
// a 100-cycle window; a second instance with a 200-cycle window is needed to
// fit 130 reverse steps into one window for the saturation scenario.
module tb_sc_enccounter;

  logic       clk  = 1'b0;
  logic       rstn = 1'b0;
  logic       en   = 1'b0;
  logic       chA  = 1'b0;
  logic       chB  = 1'b0;

  logic [7:0] data;
  logic       load;
  logic       ovf;
  logic       err;
  logic [7:0] dataL;
  logic       loadL;
  logic       ovfL;
  logic       errL;

  int compared   = 0;
  int mismatched = 0;
  int encPos     = 0;

  always #5 clk = ~clk;

  sc_enccounter #(
    .ENCCOUNTER_DATAWIDTH    (8),
    .ENCCOUNTER_WINDOW_CYCLES(100)
  ) dut (
    .SC_ENCCOUNTER_CLOCK_50        (clk),
    .SC_ENCCOUNTER_RESET_InLow     (rstn),
    .SC_ENCCOUNTER_enable_InHigh   (en),
    .SC_ENCCOUNTER_chA_In          (chA),
    .SC_ENCCOUNTER_chB_In          (chB),
    .SC_ENCCOUNTER_data_OutBus     (data),
    .SC_ENCCOUNTER_load_OutLow     (load),
    .SC_ENCCOUNTER_overflow_OutHigh(ovf),
    .SC_ENCCOUNTER_error_OutHigh   (err)
  );

  sc_enccounter #(
    .ENCCOUNTER_DATAWIDTH    (8),
    .ENCCOUNTER_WINDOW_CYCLES(200)
  ) dutLong (
    .SC_ENCCOUNTER_CLOCK_50        (clk),
    .SC_ENCCOUNTER_RESET_InLow     (rstn),
    .SC_ENCCOUNTER_enable_InHigh   (en),
    .SC_ENCCOUNTER_chA_In          (chA),
    .SC_ENCCOUNTER_chB_In          (chB),
    .SC_ENCCOUNTER_data_OutBus     (dataL),
    .SC_ENCCOUNTER_load_OutLow     (loadL),
    .SC_ENCCOUNTER_overflow_OutHigh(ovfL),
    .SC_ENCCOUNTER_error_OutHigh   (errL)
  );

  // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setPos(input int p);
    encPos = p & 3;
    case (encPos)
      0:       {chA, chB} = 2'b00;
      1:       {chA, chB} = 2'b01;
      2:       {chA, chB} = 2'b11;
      default: {chA, chB} = 2'b10;
    endcase
  endtask

  task automatic stepFwd();  setPos(encPos + 1); endtask
  task automatic stepRev();  setPos(encPos + 3); endtask
  task automatic stepBoth(); setPos(encPos + 2); endtask

  task automatic test_reset();
    rstn = 1'b0; en = 1'b0; setPos(0);
    tick(); tick();
    compared++; if (load !== 1'b1) begin mismatched++; $display("FAIL reset_load: got %b want 1", load); end
    compared++; if (data !== 8'd0) begin mismatched++; $display("FAIL reset_data: got %0d want 0", data); end
    compared++; if (ovf !== 1'b0 || err !== 1'b0) begin mismatched++; $display("FAIL reset_flags: got ovf=%b err=%b want 0/0", ovf, err); end
    compared++; if (loadL !== 1'b1 || dataL !== 8'd0) begin mismatched++; $display("FAIL reset_long: got load=%b data=%0d want 1/0", loadL, dataL); end
    rstn = 1'b1;
    $display("reset: load=%b data=%0d ovf=%b err=%b", load, data, ovf, err);
  endtask

  task automatic test_idle();
    int bad = 0;
    en = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if (k % 7 == 0) stepFwd();
      tick();
      if (load !== 1'b1 || data !== 8'd0 || ovf !== 1'b0 || err !== 1'b0) bad++;
    end
    compared++; if (bad !== 0) begin mismatched++; $display("FAIL idle_outputs: got %0d bad cycles want 0", bad); end
    $display("idle: 300 cycles, load=%b data=%0d", load, data);
  endtask

  task automatic test_forward();
    int lowCnt = 0;
    en = 1'b1;
    tick();  // IDLE -> COUNT; now in window cycle 0
    for (int k = 0; k < 100; k++) begin
      if (k >= 63 && (k - 63) % 4 == 0) stepFwd();
      if (load !== 1'b1) lowCnt++;
      tick();
    end
    compared++; if (lowCnt !== 0) begin mismatched++; $display("FAIL fwd_early_strobe: got %0d low cycles want 0", lowCnt); end
    compared++; if (load !== 1'b0) begin mismatched++; $display("FAIL fwd_strobe: got %b want 0", load); end
    compared++; if (data !== 8'd10) begin mismatched++; $display("FAIL fwd_data: got %0d want 10", data); end
    compared++; if (ovf !== 1'b0 || err !== 1'b0) begin mismatched++; $display("FAIL fwd_flags: got ovf=%b err=%b want 0/0", ovf, err); end
    $display("publish fwd: data=%0d ovf=%b err=%b", $signed(data), ovf, err);
  endtask

  task automatic test_back_to_back();
    int lowCnt = 0;
    for (int k = 0; k < 100; k++) begin
      if (k == 1) begin
        compared++; if (load !== 1'b1) begin mismatched++; $display("FAIL b2b_pulse_width: got %b want 1", load); end
      end
      if (k > 0 && load !== 1'b1) lowCnt++;
      tick();
    end
    compared++; if (lowCnt !== 0) begin mismatched++; $display("FAIL b2b_early_strobe: got %0d want 0", lowCnt); end
    compared++; if (load !== 1'b0 || data !== 8'd0) begin mismatched++; $display("FAIL b2b_publish: got load=%b data=%0d want 0/0", load, data); end
    $display("publish b2b: data=%0d ovf=%b err=%b", $signed(data), ovf, err);
  endtask

  task automatic test_error();
    for (int k = 0; k < 100; k++) begin
      if (k == 10) stepBoth();
      if (k == 20 || k == 21 || k == 22) stepFwd();
      tick();
    end
    compared++; if (load !== 1'b0 || data !== 8'd3) begin mismatched++; $display("FAIL err_data: got load=%b data=%0d want 0/3", load, data); end
    compared++; if (err !== 1'b1 || ovf !== 1'b0) begin mismatched++; $display("FAIL err_flags: got ovf=%b err=%b want 0/1", ovf, err); end
    $display("publish err: data=%0d ovf=%b err=%b", $signed(data), ovf, err);
  endtask

  task automatic test_disable();
    int lowCnt = 0;
    for (int k = 0; k < 100; k++) begin
      if (k == 30 || k == 40) stepFwd();
      if (k == 99) begin en = 1'b0; stepFwd(); end
      if (k > 0 && load !== 1'b1) lowCnt++;
      tick();
    end
    for (int k = 0; k < 20; k++) begin
      if (load !== 1'b1) lowCnt++;
      tick();
    end
    compared++; if (lowCnt !== 0) begin mismatched++; $display("FAIL dis_no_strobe: got %0d low cycles want 0", lowCnt); end
    compared++; if (data !== 8'd3 || err !== 1'b1 || ovf !== 1'b0) begin mismatched++; $display("FAIL dis_hold: got data=%0d ovf=%b err=%b want 3/0/1", data, ovf, err); end
    en = 1'b1;
    tick();
    lowCnt = 0;
    for (int k = 0; k < 100; k++) begin
      if (k >= 5 && k <= 11) stepFwd();
      if (load !== 1'b1) lowCnt++;
      tick();
    end
    compared++; if (lowCnt !== 0) begin mismatched++; $display("FAIL reen_early_strobe: got %0d want 0", lowCnt); end
    compared++; if (load !== 1'b0 || data !== 8'd7 || err !== 1'b0) begin mismatched++; $display("FAIL reen_publish: got load=%b data=%0d err=%b want 0/7/0", load, data, err); end
    $display("publish reen: data=%0d ovf=%b err=%b", $signed(data), ovf, err);
  endtask

  task automatic test_reset_midwindow();
    int bad = 0;
    for (int k = 0; k < 50; k++) begin
      if (k == 10 || k == 20 || k == 30 || k == 40 || k == 45) stepFwd();
      tick();
    end
    rstn = 1'b0;
    tick();
    compared++; if (load !== 1'b1 || data !== 8'd0 || ovf !== 1'b0 || err !== 1'b0) begin mismatched++; $display("FAIL midrst_outputs: got load=%b data=%0d ovf=%b err=%b want 1/0/0/0", load, data, ovf, err); end
    rstn = 1'b1;
    tick();  // enable still high: IDLE -> COUNT
    for (int k = 0; k < 100; k++) begin
      if (k == 3 || k == 50 || k == 60 || k == 99) stepFwd();
      if (load !== 1'b1 || data !== 8'd0) bad++;
      tick();
    end
    compared++; if (bad !== 0) begin mismatched++; $display("FAIL midrst_window: got %0d bad cycles want 0", bad); end
    compared++; if (load !== 1'b0 || data !== 8'd4) begin mismatched++; $display("FAIL midrst_publish: got load=%b data=%0d want 0/4", load, data); end
    $display("publish midrst: data=%0d ovf=%b err=%b", $signed(data), ovf, err);
  endtask

  task automatic test_overflow();
    int lowCnt = 0;
    rstn = 1'b0; en = 1'b0;
    tick();
    rstn = 1'b1; en = 1'b1;
    tick();
    for (int k = 0; k < 200; k++) begin
      if (k < 130) stepRev();
      if (loadL !== 1'b1) lowCnt++;
      tick();
    end
    compared++; if (lowCnt !== 0) begin mismatched++; $display("FAIL ovf_early_strobe: got %0d want 0", lowCnt); end
    compared++; if (loadL !== 1'b0 || dataL !== 8'h80) begin mismatched++; $display("FAIL ovf_data: got load=%b data=0x%h want 0/0x80", loadL, dataL); end
    compared++; if (ovfL !== 1'b1 || errL !== 1'b0) begin mismatched++; $display("FAIL ovf_flags: got ovf=%b err=%b want 1/0", ovfL, errL); end
    $display("publish ovf: data=%0d ovf=%b err=%b", $signed(dataL), ovfL, errL);
    for (int k = 0; k < 200; k++) tick();
    compared++; if (loadL !== 1'b0 || ovfL !== 1'b0 || dataL !== 8'd0) begin mismatched++; $display("FAIL ovf_clear: got load=%b ovf=%b data=%0d want 0/0/0", loadL, ovfL, dataL); end
    $display("publish clean: data=%0d ovf=%b err=%b", $signed(dataL), ovfL, errL);
    en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_idle();
    test_forward();
    test_back_to_back();
    test_error();
    test_disable();
    test_reset_midwindow();
    test_overflow();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
